// File: rtl/uart_tx_cfg_pkg.sv
// uart_tx_cfg_pkg: parity-mode constants and the frame state encoding shared by the UART blocks
package uart_tx_cfg_pkg;
   localparam int UART_PAR_NONE = 0;
   localparam int UART_PAR_ODD  = 1;
   localparam int UART_PAR_EVEN = 2;
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;
endpackage

// File: rtl/uart_tx_cfg_baud_gen.sv
// baud_gen: one-clock tick every DIV clocks, phase-reset by restart
module baud_gen #(
   parameter int DIV = 104
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   output logic tick
);
   localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
   logic [W-1:0] cnt_q, cnt_d;
   always_comb begin
      tick  = cnt_q == W'(DIV - 1);
      cnt_d = (restart || tick) ? '0 : cnt_q + 1'b1;
   end
   always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: UART transmitter with internal baud divider and data_rdy/fetch handshake
module uart_tx_cfg
   import uart_tx_cfg_pkg::*;
#(
   parameter int DIV    = 104,
   parameter int BITS   = 8,
   parameter int PARITY = 0,
   parameter int STOP   = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            data_rdy,
   input  logic [BITS-1:0] data,
   output logic            out,
   output logic            fetch,
   output logic            busy
);
   localparam bit HAS_PAR = PARITY != UART_PAR_NONE;
   state_e          state_q, state_d;
   logic [BITS-1:0] sh_q, sh_d;
   logic [3:0]      bit_q, bit_d;
   logic            stop_q, stop_d;
   logic            par_q, par_d, out_q, out_d, fetch_q, fetch_d, busy_q, busy_d;
   logic            latch, tick;
   baud_gen #(.DIV(DIV)) u_baud (.clk(clk), .rst(rst), .restart(latch), .tick(tick));
   always_comb begin
      state_d = state_q;
      sh_d    = sh_q;
      bit_d   = bit_q;
      stop_d  = stop_q;
      par_d   = par_q;
      out_d   = out_q;
      busy_d  = busy_q;
      fetch_d = 1'b0;
      latch   = 1'b0;
      case (state_q)
         S_IDLE: begin
            out_d = 1'b1;
            latch = data_rdy;
         end
         S_START: if (tick) begin
            state_d = S_DATA;
            out_d   = sh_q[0];
            sh_d    = sh_q >> 1;
            bit_d   = '0;
         end
         S_DATA: if (tick) begin
            if (bit_q == 4'(BITS - 1)) begin
               state_d = HAS_PAR ? S_PARITY : S_STOP;
               out_d   = HAS_PAR ? par_q : 1'b1;
               stop_d  = 1'b0;
            end else begin
               out_d = sh_q[0];
               sh_d  = sh_q >> 1;
               bit_d = bit_q + 4'd1;
            end
         end
         S_PARITY: if (tick) begin
            state_d = S_STOP;
            out_d   = 1'b1;
            stop_d  = 1'b0;
         end
         S_STOP: if (tick) begin
            if (stop_q == 1'(STOP - 1)) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
               out_d   = 1'b1;
               latch   = data_rdy;
            end else begin
               stop_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // a latch from the final stop edge chains straight into the next start bit
      if (latch) begin
         state_d = S_START;
         sh_d    = data;
         par_d   = (PARITY == UART_PAR_ODD) ? ~^data : ^data;
         out_d   = 1'b0;
         fetch_d = 1'b1;
         busy_d  = 1'b1;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         sh_q    <= '0;
         bit_q   <= '0;
         stop_q  <= 1'b0;
         par_q   <= 1'b0;
         out_q   <= 1'b1;
         fetch_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         bit_q   <= bit_d;
         stop_q  <= stop_d;
         par_q   <= par_d;
         out_q   <= out_d;
         fetch_q <= fetch_d;
         busy_q  <= busy_d;
      end
   end
   assign out   = out_q;
   assign fetch = fetch_q;
   assign busy  = busy_q;
endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: checks 8N1, 8E1 and 7O2 transmitters against a frame-level reference model
module tb_uart_tx_cfg;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] rdy = '0;
   logic [2:0] o, f, b;
   logic [8:0] dat [3];
   int         div_c  [3] = '{4, 4, 3};
   int         bits_c [3] = '{8, 8, 7};
   int         par_c  [3] = '{0, 2, 1};
   int         stop_c [3] = '{1, 1, 2};
   int         checks = 0;
   int         errors = 0;
   always #5 clk = ~clk;

   uart_tx_cfg #(.DIV(4), .BITS(8), .PARITY(0), .STOP(1)) u0 (
      .clk(clk), .rst(rst), .data_rdy(rdy[0]), .data(dat[0][7:0]), .out(o[0]), .fetch(f[0]), .busy(b[0]));
   uart_tx_cfg #(.DIV(4), .BITS(8), .PARITY(2), .STOP(1)) u1 (
      .clk(clk), .rst(rst), .data_rdy(rdy[1]), .data(dat[1][7:0]), .out(o[1]), .fetch(f[1]), .busy(b[1]));
   uart_tx_cfg #(.DIV(3), .BITS(7), .PARITY(1), .STOP(2)) u2 (
      .clk(clk), .rst(rst), .data_rdy(rdy[2]), .data(dat[2][6:0]), .out(o[2]), .fetch(f[2]), .busy(b[2]));

   typedef struct {
      int         k;
      logic [8:0] d;
      int         exp_par;
      int         exp_len;
   } vec_t;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int flen(input int k);
      return (1 + bits_c[k] + ((par_c[k] != 0) ? 1 : 0) + stop_c[k]) * div_c[k];
   endfunction

   // line level c clocks after the latch edge, derived from the frame layout
   function automatic int exp_bit(input int k, input logic [8:0] d, input int c);
      int i = c / div_c[k];
      int ones = 0;
      for (int j = 0; j < bits_c[k]; j++) ones += int'(d[j]);
      if (i == 0) return 0;
      if (i <= bits_c[k]) return int'(d[i-1]);
      if (par_c[k] != 0 && i == bits_c[k] + 1) return (par_c[k] == 1) ? ((ones % 2 == 0) ? 1 : 0) : ones % 2;
      return 1;
   endfunction

   task automatic run_frame(input int k, input logic [8:0] d, output int ps, output int ln, output int nf);
      int len = flen(k);
      ps = -1;
      nf = 0;
      ln = 0;
      rdy[k] = 1'b1;
      dat[k] = d;
      step();
      while (b[k] && ln < 300) begin
         if (ln < len) begin
            chk("out", int'(o[k]), exp_bit(k, d, ln));
            chk("fetch", int'(f[k]), (ln == 0) ? 1 : 0);
         end
         nf += int'(f[k]);
         if (ln == (1 + bits_c[k]) * div_c[k]) ps = int'(o[k]);
         rdy[k] = (ln < len - 1) ? 1'($urandom) : 1'b0;
         dat[k] = 9'($urandom);
         step();
         ln++;
      end
      chk("end_out", int'(o[k]), 1);
      chk("end_fetch", int'(f[k]), 0);
   endtask

   initial begin
      vec_t tbl [5];
      int ps, ln, nf, k;
      logic [8:0] d;
      for (int i = 0; i < 3; i++) dat[i] = '0;
      tbl[0] = '{0, 9'h55, -1, 40};
      tbl[1] = '{1, 9'hA5,  0, 44};
      tbl[2] = '{1, 9'hA4,  1, 44};
      tbl[3] = '{2, 9'h7F,  0, 33};
      tbl[4] = '{2, 9'h00,  1, 33};
      step();
      step();
      for (int i = 0; i < 3; i++) begin
         chk("rst_out", int'(o[i]), 1);
         chk("rst_fetch", int'(f[i]), 0);
         chk("rst_busy", int'(b[i]), 0);
      end
      rst = 1'b0;
      step();
      for (int i = 0; i < 5; i++) begin
         run_frame(tbl[i].k, tbl[i].d, ps, ln, nf);
         if (tbl[i].exp_par >= 0) chk("parity", ps, tbl[i].exp_par);
         chk("frame_len", ln, tbl[i].exp_len);
         chk("fetch_count", nf, 1);
         step();
      end
      repeat (12) begin
         k = int'($urandom_range(0, 2));
         d = 9'($urandom);
         run_frame(k, d, ps, ln, nf);
         chk("rand_len", ln, flen(k));
         chk("rand_fetch_count", nf, 1);
         repeat (int'($urandom_range(0, 3))) step();
      end
      rdy[0] = 1'b1;
      dat[0] = 9'h12;
      step();
      for (int c = 0; c <= 80; c++) begin
         chk("b2b_out", int'(o[0]), (c < 40) ? exp_bit(0, 9'h12, c) : (c < 80) ? exp_bit(0, 9'h34, c - 40) : 1);
         chk("b2b_fetch", int'(f[0]), (c == 0 || c == 40) ? 1 : 0);
         chk("b2b_busy", int'(b[0]), (c < 80) ? 1 : 0);
         if (c == 0) dat[0] = 9'h34;
         if (c == 40) rdy[0] = 1'b0;
         if (c < 80) step();
      end
      rdy = '0;
      repeat (200) begin
         dat[0] = 9'($urandom);
         step();
         chk("idle_out", int'(o[0]), 1);
         chk("idle_fetch", int'(f[0]), 0);
         chk("idle_busy", int'(b[0]), 0);
      end
      rdy[0] = 1'b1;
      dat[0] = 9'hB6;
      step();
      rdy[0] = 1'b0;
      repeat (17) step();
      chk("pre_rst_bit3", int'(o[0]), exp_bit(0, 9'hB6, 17));
      rst = 1'b1;
      step();
      chk("mid_rst_out", int'(o[0]), 1);
      chk("mid_rst_busy", int'(b[0]), 0);
      chk("mid_rst_fetch", int'(f[0]), 0);
      rst = 1'b0;
      run_frame(0, 9'hC3, ps, ln, nf);
      chk("post_rst_len", ln, 40);
      chk("post_rst_fetch_count", nf, 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout");
      $fatal(1);
   end
endmodule
